// File: rtl/branch_predictor_pkg.sv
// -----------------------------------------------------------------------------
// branch_predictor_pkg
// Shared definitions for the RV32I dynamic branch predictor:
//   - branch_type_e : EX-stage branch type codes, shared with BranchDecisionMaking
//   - ctr_e         : 2-bit saturating counter states (SNT/WNT/WT/ST)
//   - BTB_IDX_W_DEFAULT : default BTB index width (2^6 = 64 entries)
//   - ctr_step()    : saturating counter update toward the resolved outcome
// -----------------------------------------------------------------------------
package branch_predictor_pkg;

  localparam int BTB_IDX_W_DEFAULT = 6;

  typedef enum logic [2:0] {
    NOBRANCH = 3'd0,
    BEQ      = 3'd1,
    BNE      = 3'd2,
    BLT      = 3'd3,
    BLTU     = 3'd4,
    BGE      = 3'd5,
    BGEU     = 3'd6
  } branch_type_e;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  // Move one step toward the outcome, holding at the ST/SNT ends.
  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != ST) nxt = ctr + 2'd1;
    end else begin
      if (ctr != SNT) nxt = ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// -----------------------------------------------------------------------------
// branch_predictor_if
// Pipeline <-> predictor signal bundle.
//   IF  : PCF (in), PredTakenF / PredTargetF (out)
//   EX  : BranchTypeE, BranchE, PCE, BranchTargetE, PredTakenE, PredTargetE,
//         StallE (in); MispredictE / RedirectPCE (out)
//   Stats: BranchCount / MissCount (out, STAT_W bits)
// master = pipeline side, slave = predictor side.
// -----------------------------------------------------------------------------
interface branch_predictor_if
  import branch_predictor_pkg::*;
#(
  parameter int STAT_W = 32
);
  logic [31:0]       PCF;
  logic              PredTakenF;
  logic [31:0]       PredTargetF;
  branch_type_e      BranchTypeE;
  logic              BranchE;
  logic [31:0]       PCE;
  logic [31:0]       BranchTargetE;
  logic              PredTakenE;
  logic [31:0]       PredTargetE;
  logic              StallE;
  logic              MispredictE;
  logic [31:0]       RedirectPCE;
  logic [STAT_W-1:0] BranchCount;
  logic [STAT_W-1:0] MissCount;

  modport master (
    output PCF, BranchTypeE, BranchE, PCE, BranchTargetE, PredTakenE, PredTargetE, StallE,
    input  PredTakenF, PredTargetF, MispredictE, RedirectPCE, BranchCount, MissCount
  );

  modport slave (
    input  PCF, BranchTypeE, BranchE, PCE, BranchTargetE, PredTakenE, PredTargetE, StallE,
    output PredTakenF, PredTargetF, MispredictE, RedirectPCE, BranchCount, MissCount
  );
endinterface

// File: rtl/branch_predictor_btb_array.sv
// -----------------------------------------------------------------------------
// branch_predictor_btb_array  (the btb_array storage of the predictor)
// Direct-mapped BTB storage: valid / tag / target / ctr per entry.
//   clk            : clock
//   clr            : synchronous clear-all of valid bits and counters
//   rf_idx -> rf_* : async read port used by the IF lookup
//   re_idx -> re_* : async read port used by the EX update (hit + old state)
//   we, wr_*       : synchronous write port (one entry per cycle)
// A read of the entry being written returns the old contents this cycle.
// -----------------------------------------------------------------------------
module branch_predictor_btb_array #(
  parameter int IDX_W = 6,
  parameter int TAG_W = 24
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [IDX_W-1:0] rf_idx,
  output logic             rf_valid,
  output logic [TAG_W-1:0] rf_tag,
  output logic [31:0]      rf_target,
  output logic [1:0]       rf_ctr,
  input  logic [IDX_W-1:0] re_idx,
  output logic             re_valid,
  output logic [TAG_W-1:0] re_tag,
  output logic [31:0]      re_target,
  output logic [1:0]       re_ctr,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_valid,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_target,
  input  logic [1:0]       wr_ctr
);
  localparam int NENT = 1 << IDX_W;

  logic             valid_arr  [NENT];
  logic [TAG_W-1:0] tag_arr    [NENT];
  logic [31:0]      target_arr [NENT];
  logic [1:0]       ctr_arr    [NENT];

  for (genvar gi = 0; gi < NENT; gi++) begin : g_entry
    logic             valid_q, valid_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [31:0]      target_q, target_d;
    logic [1:0]       ctr_q, ctr_d;

    always_comb begin
      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
      ctr_d    = ctr_q;
      if (clr) begin
        // Tag/target are don't-care once valid is low, so only these clear.
        valid_d = 1'b0;
        ctr_d   = 2'b00;
      end else if (we && (wr_idx == IDX_W'(gi))) begin
        valid_d  = wr_valid;
        tag_d    = wr_tag;
        target_d = wr_target;
        ctr_d    = wr_ctr;
      end
    end

    always_ff @(posedge clk) begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end

    assign valid_arr[gi]  = valid_q;
    assign tag_arr[gi]    = tag_q;
    assign target_arr[gi] = target_q;
    assign ctr_arr[gi]    = ctr_q;
  end

  assign rf_valid  = valid_arr[rf_idx];
  assign rf_tag    = tag_arr[rf_idx];
  assign rf_target = target_arr[rf_idx];
  assign rf_ctr    = ctr_arr[rf_idx];

  assign re_valid  = valid_arr[re_idx];
  assign re_tag    = tag_arr[re_idx];
  assign re_target = target_arr[re_idx];
  assign re_ctr    = ctr_arr[re_idx];

endmodule

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
// BTB + 2-bit counter branch predictor and EX-stage redirect controller.
//   clk   : pipeline clock
//   rst_n : synchronous active-low reset (clears table and stats)
//   bp    : branch_predictor_if.slave
//           IF lookup  PCF -> PredTakenF / PredTargetF (combinational)
//           EX resolve -> MispredictE / RedirectPCE (combinational)
//           stats      BranchCount / MissCount (saturating)
// Table writes happen on the clock edge of an unstalled EX cycle.
// -----------------------------------------------------------------------------
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int BTB_IDX_W = BTB_IDX_W_DEFAULT,
  parameter int STAT_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  branch_predictor_if.slave   bp
);
  localparam int TAG_W = 32 - BTB_IDX_W - 2;

  logic [BTB_IDX_W-1:0] idx_f, idx_e;
  logic [TAG_W-1:0]     tag_f, tag_e;

  logic             rf_valid, re_valid;
  logic [TAG_W-1:0] rf_tag, re_tag;
  logic [31:0]      rf_target, re_target;
  logic [1:0]       rf_ctr, re_ctr;

  logic             we;
  logic             wr_valid;
  logic [TAG_W-1:0] wr_tag;
  logic [31:0]      wr_target;
  logic [1:0]       wr_ctr;

  logic hit_f, hit_e, pred_taken_f;
  logic is_branch, resolve_en, mispredict_raw;
  logic [31:0] redirect_pc;

  logic [STAT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [STAT_W-1:0] miss_cnt_q, miss_cnt_d;

  // Byte-offset bits never matter for word-aligned RV32I PCs.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{bp.PCF[1:0], bp.PCE[1:0]};

  assign idx_f = bp.PCF[BTB_IDX_W+1:2];
  assign tag_f = bp.PCF[31:BTB_IDX_W+2];
  assign idx_e = bp.PCE[BTB_IDX_W+1:2];
  assign tag_e = bp.PCE[31:BTB_IDX_W+2];

  branch_predictor_btb_array #(
    .IDX_W (BTB_IDX_W),
    .TAG_W (TAG_W)
  ) u_btb (
    .clk       (clk),
    .clr       (!rst_n),
    .rf_idx    (idx_f),
    .rf_valid  (rf_valid),
    .rf_tag    (rf_tag),
    .rf_target (rf_target),
    .rf_ctr    (rf_ctr),
    .re_idx    (idx_e),
    .re_valid  (re_valid),
    .re_tag    (re_tag),
    .re_target (re_target),
    .re_ctr    (re_ctr),
    .we        (we),
    .wr_idx    (idx_e),
    .wr_valid  (wr_valid),
    .wr_tag    (wr_tag),
    .wr_target (wr_target),
    .wr_ctr    (wr_ctr)
  );

  // IF lookup
  assign hit_f        = rf_valid && (rf_tag == tag_f);
  assign pred_taken_f = hit_f && rf_ctr[1];
  assign bp.PredTakenF  = pred_taken_f;
  assign bp.PredTargetF = pred_taken_f ? rf_target : 32'd0;

  // EX resolution
  assign is_branch  = (bp.BranchTypeE != NOBRANCH);
  assign resolve_en = rst_n && !bp.StallE;
  assign hit_e      = re_valid && (re_tag == tag_e);

  always_comb begin
    mispredict_raw = 1'b0;
    redirect_pc    = bp.PCE + 32'd4;
    if (is_branch && bp.BranchE) begin
      redirect_pc    = bp.BranchTargetE;
      mispredict_raw = !bp.PredTakenE || (bp.PredTargetE != bp.BranchTargetE);
    end else begin
      // Not-taken branch or a non-branch that was predicted taken (alias):
      // either way a taken prediction sent fetch down the wrong path.
      mispredict_raw = bp.PredTakenE;
    end
  end

  assign bp.MispredictE = resolve_en && mispredict_raw;
  assign bp.RedirectPCE = redirect_pc;

  // Table update, indexed by PCE
  always_comb begin
    we        = 1'b0;
    wr_valid  = 1'b1;
    wr_tag    = tag_e;
    wr_target = re_target;
    wr_ctr    = re_ctr;
    if (resolve_en) begin
      if (is_branch) begin
        if (hit_e) begin
          we     = 1'b1;
          wr_ctr = ctr_step(re_ctr, bp.BranchE);
          if (bp.BranchE) wr_target = bp.BranchTargetE;
        end else if (bp.BranchE) begin
          we        = 1'b1;
          wr_target = bp.BranchTargetE;
          wr_ctr    = WT;
        end
      end else if (hit_e) begin
        // Non-branch hitting in the BTB: drop the stale entry.
        we       = 1'b1;
        wr_valid = 1'b0;
      end
    end
  end

  // Saturating performance counters
  always_comb begin
    branch_cnt_d = branch_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    if (resolve_en && is_branch && (branch_cnt_q != '1))
      branch_cnt_d = branch_cnt_q + 1'b1;
    if (bp.MispredictE && (miss_cnt_q != '1))
      miss_cnt_d = miss_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      branch_cnt_q <= '0;
      miss_cnt_q   <= '0;
    end else begin
      branch_cnt_q <= branch_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign bp.BranchCount = branch_cnt_q;
  assign bp.MissCount   = miss_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
// Self-checking bench for branch_predictor: directed scenarios followed by
// randomized traffic, all compared against a table-of-records reference model.
// -----------------------------------------------------------------------------
module tb_branch_predictor;
  import branch_predictor_pkg::*;

  localparam int IDX_W  = 6;
  localparam int NENT   = 1 << IDX_W;
  localparam int STAT_W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_predictor_if #(.STAT_W(STAT_W)) bp_if ();

  branch_predictor #(
    .BTB_IDX_W (IDX_W),
    .STAT_W    (STAT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (bp_if)
  );

  int vec_cnt  = 0;
  int miss_cnt = 0;
  int txn      = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit        valid;
    bit [31:0] pc;      // full PC of the owning branch
    bit [31:0] target;
    int        conf;    // 0..3, predicts taken when >= 2
  } ent_t;

  ent_t      tbl [NENT];
  bit [31:0] m_brc;
  bit [31:0] m_missc;
  bit        model_valid = 1'b0;

  function automatic int slot(input bit [31:0] pc);
    return int'((pc >> 2) % NENT);
  endfunction

  function automatic bit m_hit(input bit [31:0] pc);
    int s;
    s = slot(pc);
    return tbl[s].valid && ((tbl[s].pc >> (IDX_W + 2)) == (pc >> (IDX_W + 2)));
  endfunction

  task automatic m_pred(input bit [31:0] pc, output bit pt, output bit [31:0] tgt);
    pt  = m_hit(pc) && (tbl[slot(pc)].conf >= 2);
    tgt = pt ? tbl[slot(pc)].target : 32'd0;
  endtask

  task automatic m_update(input bit is_br, input bit exp_mp);
    int s;
    bit h;
    if (!rst_n) begin
      foreach (tbl[i]) begin
        tbl[i].valid = 1'b0;
        tbl[i].conf  = 0;
      end
      m_brc       = 0;
      m_missc     = 0;
      model_valid = 1'b1;
    end else if (!bp_if.StallE) begin
      s = slot(bp_if.PCE);
      h = m_hit(bp_if.PCE);
      if (is_br && m_brc != 32'hFFFF_FFFF) m_brc++;
      if (exp_mp && m_missc != 32'hFFFF_FFFF) m_missc++;
      if (is_br) begin
        if (h) begin
          if (bp_if.BranchE) begin
            tbl[s].conf   = (tbl[s].conf < 3) ? tbl[s].conf + 1 : 3;
            tbl[s].target = bp_if.BranchTargetE;
          end else begin
            tbl[s].conf = (tbl[s].conf > 0) ? tbl[s].conf - 1 : 0;
          end
        end else if (bp_if.BranchE) begin
          tbl[s].valid  = 1'b1;
          tbl[s].pc     = bp_if.PCE;
          tbl[s].target = bp_if.BranchTargetE;
          tbl[s].conf   = 2;
        end
      end else if (h) begin
        tbl[s].valid = 1'b0;
      end
    end
  endtask

  // One clock: check combinational outputs, log, advance model and DUT.
  task automatic cycle();
    bit        is_br, wrong, exp_mp, exp_pt;
    bit [31:0] exp_rd, exp_tgt;
    #2;
    is_br = (bp_if.BranchTypeE != NOBRANCH);
    if (is_br && bp_if.BranchE) begin
      wrong  = !bp_if.PredTakenE || (bp_if.PredTargetE != bp_if.BranchTargetE);
      exp_rd = bp_if.BranchTargetE;
    end else begin
      wrong  = bp_if.PredTakenE;
      exp_rd = bp_if.PCE + 32'd4;
    end
    exp_mp = rst_n && !bp_if.StallE && wrong;
    check_val("MispredictE", bp_if.MispredictE, exp_mp);
    if (rst_n && !bp_if.StallE) check_val("RedirectPCE", bp_if.RedirectPCE, exp_rd);
    if (model_valid) begin
      m_pred(bp_if.PCF, exp_pt, exp_tgt);
      check_val("PredTakenF", bp_if.PredTakenF, exp_pt);
      check_val("PredTargetF", bp_if.PredTargetF, exp_tgt);
      check_val("BranchCount", bp_if.BranchCount, m_brc);
      check_val("MissCount", bp_if.MissCount, m_missc);
    end
    $display("txn %0d: rst_n=%0b stall=%0b PCF=%08h pred=%0b/%08h PCE=%08h type=%0d taken=%0b mispredict=%0b redirect=%08h",
             txn, rst_n, bp_if.StallE, bp_if.PCF, bp_if.PredTakenF, bp_if.PredTargetF,
             bp_if.PCE, bp_if.BranchTypeE, bp_if.BranchE, bp_if.MispredictE, bp_if.RedirectPCE);
    txn++;
    m_update(is_br, exp_mp);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit [31:0] pcf, input bit [2:0] bt, input bit br,
                       input bit [31:0] pce, input bit [31:0] tgt, input bit pte,
                       input bit [31:0] ptgt, input bit stall, input bit rn);
    bp_if.PCF           = pcf;
    bp_if.BranchTypeE   = branch_type_e'(bt);
    bp_if.BranchE       = br;
    bp_if.PCE           = pce;
    bp_if.BranchTargetE = tgt;
    bp_if.PredTakenE    = pte;
    bp_if.PredTargetE   = ptgt;
    bp_if.StallE        = stall;
    rst_n               = rn;
    cycle();
  endtask

  // Constant-expectation lookup probe between clock edges.
  task automatic peek_pred(input string tag, input bit [31:0] pcf, input bit pt, input bit [31:0] tgt);
    bp_if.PCF = pcf;
    #2;
    check_val({tag, "_taken"}, bp_if.PredTakenF, pt);
    check_val({tag, "_target"}, bp_if.PredTargetF, tgt);
  endtask

  bit [31:0] pool [8] = '{32'h100, 32'h104, 32'h180, 32'h200, 32'h204, 32'h300, 32'h1100, 32'h40};

  initial begin
    bit        pt;
    bit [31:0] ptgt, pce, pcf, tgt;
    bit [2:0]  bt;

    // Reset
    drive(32'h100, NOBRANCH, 0, 32'h40, 0, 0, 0, 0, 0);
    drive(32'h100, NOBRANCH, 0, 32'h40, 0, 0, 0, 0, 0);
    peek_pred("reset", 32'h100, 0, 0);
    check_val("reset_brc", bp_if.BranchCount, 0);
    check_val("reset_missc", bp_if.MissCount, 0);

    // Cold taken BEQ allocates and becomes visible next cycle
    drive(32'h100, BEQ, 1, 32'h100, 32'h200, 0, 0, 0, 1);
    peek_pred("cold", 32'h100, 1, 32'h200);

    // Saturation: two more takes (10->11->11), then two not-takens
    drive(32'h40, BEQ, 1, 32'h100, 32'h200, 1, 32'h200, 0, 1);
    drive(32'h40, BEQ, 1, 32'h100, 32'h200, 1, 32'h200, 0, 1);
    drive(32'h40, BEQ, 0, 32'h100, 32'h200, 1, 32'h200, 0, 1);
    peek_pred("sat_nt1", 32'h100, 1, 32'h200);
    drive(32'h40, BEQ, 0, 32'h100, 32'h200, 1, 32'h200, 0, 1);
    peek_pred("sat_nt2", 32'h100, 0, 0);
    check_val("sat_missc", bp_if.MissCount, 3);
    check_val("sat_brc", bp_if.BranchCount, 5);

    // Re-arm, then non-branch with a different tag (no hit) and same PC (hit)
    drive(32'h40, BEQ, 1, 32'h100, 32'h200, 0, 0, 0, 1);
    peek_pred("rearm", 32'h100, 1, 32'h200);
    drive(32'h40, NOBRANCH, 0, 32'h100 + 4 * NENT, 0, 1, 32'h200, 0, 1);
    peek_pred("alias_other_tag", 32'h100, 1, 32'h200);
    drive(32'h40, NOBRANCH, 0, 32'h100, 0, 1, 32'h200, 0, 1);
    peek_pred("alias_invalidated", 32'h100, 0, 0);

    // Stall blocks the write and the mispredict
    drive(32'h40, BNE, 1, 32'h300, 32'h500, 0, 0, 1, 1);
    peek_pred("stall", 32'h300, 0, 0);

    // Reset during an update cycle discards it
    drive(32'h40, BNE, 1, 32'h300, 32'h500, 0, 0, 0, 1);
    peek_pred("pre_rst", 32'h300, 1, 32'h500);
    drive(32'h40, BNE, 1, 32'h100, 32'h600, 0, 0, 0, 0);
    peek_pred("midrst_300", 32'h300, 0, 0);
    peek_pred("midrst_100", 32'h100, 0, 0);
    check_val("midrst_brc", bp_if.BranchCount, 0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      pce = pool[$urandom_range(0, 7)];
      pcf = pool[$urandom_range(0, 7)];
      bt  = ($urandom_range(0, 9) < 6) ? 3'($urandom_range(1, 6)) : 3'd0;
      tgt = ($urandom_range(0, 3) != 0) ? pool[$urandom_range(0, 7)] : ($urandom() & 32'hFFFF_FFFC);
      if ($urandom_range(0, 9) < 7) begin
        m_pred(pce, pt, ptgt);
      end else begin
        pt   = 1'($urandom_range(0, 1));
        ptgt = pool[$urandom_range(0, 7)];
      end
      drive(pcf, bt, 1'($urandom_range(0, 1)), pce, tgt, pt, ptgt,
            $urandom_range(0, 99) < 15, $urandom_range(0, 99) >= 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
